muldiv_sequencer: RTL
=====================

Name: muldiv_sequencer

Overview:
- Sequences the iterative multiply/divide unit hanging off the EX stage of the 5-stage MIPS pipeline.
- Issues the start pulse and op select, then counts the unit's fixed latency and pulses the HI/LO write enable on completion.
- Stalls IF/ID and injects an ID/EX bubble while a dependent instruction (MFHI/MFLO or another MULT/DIV) sits in ID.
- Sits beside the branch/jump flush logic; takes its flush as an input.

Parameters:
MULT_CYCLES, 4, RUN-state cycles for MULT/MULTU (>=1)
DIV_CYCLES, 32, RUN-state cycles for DIV/DIVU (>=1)
CNT_W, 6, counter width; must hold max(MULT_CYCLES,DIV_CYCLES)-1

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX holds a real instruction (not a bubble)
ex_mult  in  1  EX instruction is MULT/MULTU
ex_div  in  1  EX instruction is DIV/DIVU
id_hilo_read  in  1  ID instruction is MFHI/MFLO
id_muldiv  in  1  ID instruction is MULT/MULTU/DIV/DIVU
flush  in  1  ID instruction is being squashed (jump/taken branch)
md_start  out  1  one-cycle start pulse to the mul/div unit
md_op  out  1  0=mult, 1=div; valid with md_start, held while busy
hilo_we  out  1  one-cycle HI/LO register write enable
busy  out  1  state != IDLE
stall  out  1  pipeline stall request
pc_ld  out  1  PC load enable (= !stall)
IF_ID_write  out  1  IF/ID write enable (= !stall)
id_ex_bubble  out  1  zero ID/EX control fields (= stall)
md_conflict  out  1  sticky error: MULT/DIV reached EX while busy

Behaviour:
- Reset (async, rst_n=0): state=IDLE, count=0, md_op=0, md_conflict=0. md_start=0, hilo_we=0, busy=0, stall=0, pc_ld=1, IF_ID_write=1, id_ex_bubble=0.
- Reset mid-operation aborts silently. No hilo_we is issued for the aborted operation.
- States are IDLE, RUN and DONE.
- IDLE:
  - md_start = ex_valid & (ex_mult | ex_div), combinational.
  - md_op = ex_div & !ex_mult. If both are set, mult wins.
  - On an md_start edge: go to RUN, count = (selected CYCLES) - 1, register md_op.
- RUN:
  - When count == 0, go to DONE on the next edge.
  - Otherwise count decrements by 1 each cycle.
  - RUN lasts exactly CYCLES cycles.
- DONE: hilo_we=1 for this single cycle, then go to IDLE. No start is accepted in DONE.
- Latency: hilo_we is asserted exactly CYCLES+1 cycles after the md_start cycle.
- busy = 1 in RUN and DONE.
- stall = (busy | md_start) & (id_hilo_read | id_muldiv) & !flush.
  - The stall covers the start cycle through the DONE cycle inclusive.
  - The first un-stalled MFHI/MFLO therefore reaches EX after HI/LO has been written.
- flush has priority: a squashed ID instruction never causes a stall.
- flush does not cancel an operation already started. Its EX instruction has committed.
- Conflict: ex_valid & (ex_mult | ex_div) while busy:
  - The request is ignored; no restart and no count change.
  - md_conflict is set and holds until reset.
- The pipeline only ever sees pc_ld, IF_ID_write and id_ex_bubble derived from stall, with no extra registered delay.

Test Plan:
1. MULT_CYCLES=4; ex_valid=1, ex_mult=1 at cycle T:
   - md_start=1 and md_op=0 at T.
   - busy=1 for T+1..T+5.
   - hilo_we=1 only at T+5.
   - stall=0 throughout (ID is independent).
2. DIV (DIV_CYCLES=32) at T with id_hilo_read=1 held:
   - stall=1, pc_ld=0, IF_ID_write=0, id_ex_bubble=1 for T..T+33 (34 cycles).
   - hilo_we at T+33.
   - stall=0 at T+34.
3. MULT at T, then id_muldiv=1 from T+1:
   - stall holds through T+5.
   - Second MULT presented to EX at T+6 gives md_start=1 at T+6 and hilo_we at T+11.
4. Busy in RUN with id_hilo_read=1 and flush=1 for one cycle:
   - stall=0 that cycle, stall=1 the next.
   - hilo_we timing unchanged.
5. rst_n pulsed low at cycle T+2 of a DIV:
   - All outputs return to reset values immediately (async).
   - No hilo_we follows.
   - A new MULT after release completes normally.
6. Forced ex_mult=1 & ex_valid=1 at T+2 of a running MULT:
   - md_start stays 0, md_conflict=1 and sticky.
   - Original hilo_we still at T+5.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Controls the iterative multiply/divide unit that sits beside the EX stage.
// When a MULT/MULTU or DIV/DIVU instruction is in EX, this block sends a
// one-cycle start pulse and the op select. It then counts the fixed latency of
// the unit and pulses the HI/LO write enable for one cycle when the result is
// ready. While the unit is busy, an instruction in ID that depends on it
// (MFHI/MFLO or another MULT/DIV) stalls IF/ID and sends a bubble into ID/EX.
//
// Ports
//   clk, rst_n    pipeline clock (rising edge), asynchronous active-low reset
//   ex_valid      EX holds a real instruction
//   ex_mult       EX instruction is MULT/MULTU
//   ex_div        EX instruction is DIV/DIVU
//   id_hilo_read  ID instruction is MFHI/MFLO
//   id_muldiv     ID instruction is MULT/MULTU/DIV/DIVU
//   flush         ID instruction is being squashed
//   md_start      one-cycle start pulse to the mul/div unit
//   md_op         0 = mult, 1 = div; valid with md_start, held while busy
//   hilo_we       one-cycle HI/LO write enable
//   busy          sequencer is not idle
//   stall         pipeline stall request
//   pc_ld         PC load enable (= !stall)
//   IF_ID_write   IF/ID write enable (= !stall)
//   id_ex_bubble  zero the ID/EX control fields (= stall)
//   md_conflict   sticky: a MULT/DIV reached EX while the unit was busy
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 32,
   parameter int CNT_W       = 6
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ex_valid,
   input  logic ex_mult,
   input  logic ex_div,
   input  logic id_hilo_read,
   input  logic id_muldiv,
   input  logic flush,
   output logic md_start,
   output logic md_op,
   output logic hilo_we,
   output logic busy,
   output logic stall,
   output logic pc_ld,
   output logic IF_ID_write,
   output logic id_ex_bubble,
   output logic md_conflict
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // The counter is loaded with CYCLES-1 and the unit leaves RUN after it
   // reaches zero, so RUN lasts exactly CYCLES cycles.
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             md_op_q, md_op_d;
   logic             conflict_q, conflict_d;
   logic             ex_md_req;
   logic             op_sel;

   assign ex_md_req = ex_valid & (ex_mult | ex_div);
   // If both decode bits are set, MULT takes priority.
   assign op_sel    = ex_div & ~ex_mult;

   // NOTE: give every always_comb output a default before the case statement.
   // Otherwise a path that does not assign it infers a latch.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      md_op_d    = md_op_q;
      conflict_d = conflict_q;
      md_start   = 1'b0;
      md_op      = md_op_q;
      hilo_we    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            md_start = ex_md_req;
            md_op    = op_sel;
            if (ex_md_req) begin
               state_d = ST_RUN;
               count_d = op_sel ? DIV_LOAD : MULT_LOAD;
               md_op_d = op_sel;
            end
         end
         ST_RUN: begin
            if (count_q == '0) begin
               state_d = ST_DONE;
            end else begin
               count_d = count_q - CNT_W'(1);
            end
         end
         ST_DONE: begin
            hilo_we = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // A new MULT/DIV that arrives while the unit is busy is dropped. The
      // error flag records it and stays set until reset.
      if ((state_q != ST_IDLE) && ex_md_req) begin
         conflict_d = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments. All registers then
   // update together at the clock edge, with no ordering races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         md_op_q    <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         md_op_q    <= md_op_d;
         conflict_q <= conflict_d;
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign md_conflict = conflict_q;

   // The stall starts in the start cycle and ends in the DONE cycle. The first
   // dependent instruction allowed through therefore reads HI/LO after the
   // write. A squashed ID instruction never stalls.
   assign stall        = (busy | md_start) & (id_hilo_read | id_muldiv) & ~flush;
   assign pc_ld        = ~stall;
   assign IF_ID_write  = ~stall;
   assign id_ex_bubble = stall;

endmodule
